// File: rtl/battle_pkg.sv
// Shared game-controller package: tank facing encoding, HID usage codes
// for the player-1 controls, and the logical key index used by the
// key input controller.
package battle_pkg;

   typedef enum logic [1:0] {
      UP    = 2'd0,
      RIGHT = 2'd1,
      DOWN  = 2'd2,
      LEFT  = 2'd3
   } dir_t;

   typedef enum logic [2:0] {
      K_UP    = 3'd0,
      K_RIGHT = 3'd1,
      K_DOWN  = 3'd2,
      K_LEFT  = 3'd3,
      K_FIRE  = 3'd4,
      K_PAUSE = 3'd5
   } key_idx_t;

   localparam int NUM_KEYS = 6;

   localparam logic [7:0] HID_W     = 8'h1A;
   localparam logic [7:0] HID_D     = 8'h07;
   localparam logic [7:0] HID_S     = 8'h16;
   localparam logic [7:0] HID_A     = 8'h04;
   localparam logic [7:0] HID_SPACE = 8'h2C;
   localparam logic [7:0] HID_P     = 8'h13;

   localparam logic [7:0] HID_UP    = 8'h52;
   localparam logic [7:0] HID_RIGHT = 8'h4F;
   localparam logic [7:0] HID_DOWN  = 8'h51;
   localparam logic [7:0] HID_LEFT  = 8'h50;

   // A key is present when either of the two report slots carries its code.
   function automatic logic key_hit(input logic [15:0] kc, input logic [7:0] code);
      return (kc[7:0] == code) || (kc[15:8] == code);
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Per-key debouncer: the debounced level only changes after DEBOUNCE
// consecutive frame samples disagree with it. rise/fall are registered
// one-frame pulses coincident with the level change.
module key_debounce #(
   parameter int DEBOUNCE = 2
) (
   input  logic frame_clk,
   input  logic Reset,
   input  logic raw,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam logic [3:0] DB_CNT = 4'(DEBOUNCE);

   logic [3:0] cnt;
   logic [3:0] cnt_inc;

   assign cnt_inc = cnt + 4'd1;

   // Count disagreeing samples; a single agreeing sample restarts the count.
   always_ff @(posedge frame_clk or negedge Reset) begin
      if (!Reset) begin
         cnt   <= '0;
         level <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         if (raw == level) begin
            cnt <= '0;
         end else if (cnt_inc == DB_CNT) begin
            cnt   <= '0;
            level <= raw;
            rise  <= raw;
            fall  <= ~raw;
         end else begin
            cnt <= cnt_inc;
         end
      end
   end

endmodule

// File: rtl/key_input_controller.sv
// Player-1 key input controller: turns the two-slot HID keycode into
// debounced, newest-press-wins movement, a rate-limited fire pulse and a
// pause toggle, all registered on frame_clk.
// Optional build macro KEY_ARROWS_EN: arrow keys also drive the directions.
module key_input_controller
   import battle_pkg::*;
#(
   parameter int DEBOUNCE      = 2,
   parameter int FIRE_COOLDOWN = 30
) (
   input  logic        frame_clk,
   input  logic        Reset,
   input  logic [15:0] keycode,
   output logic        move,
   output logic [1:0]  dir,
   output logic        fire,
   output logic        paused
);

   localparam logic [7:0] CD_LOAD = 8'(FIRE_COOLDOWN);

   logic [NUM_KEYS-1:0] raw;
   logic [NUM_KEYS-1:0] lvl;
   logic [NUM_KEYS-1:0] rise;
   logic [NUM_KEYS-1:0] fall;
   logic                unused_keys;

   dir_t       act_dir, act_dir_nx;
   logic       act_mv, act_mv_nx;
   logic       paused_nx;
   logic       hold_out;
   logic       fire_nx;
   logic [7:0] cooldown, cooldown_nx;

   // Lowest index wins: UP > RIGHT > DOWN > LEFT.
   function automatic dir_t pick_dir(input logic [3:0] keys);
      if (keys[0]) return UP;
      if (keys[1]) return RIGHT;
      if (keys[2]) return DOWN;
      return LEFT;
   endfunction

   // Map the report slots onto the logical keys before debouncing.
   always_comb begin
      raw          = '0;
      raw[K_UP]    = key_hit(keycode, HID_W);
      raw[K_RIGHT] = key_hit(keycode, HID_D);
      raw[K_DOWN]  = key_hit(keycode, HID_S);
      raw[K_LEFT]  = key_hit(keycode, HID_A);
      raw[K_FIRE]  = key_hit(keycode, HID_SPACE);
      raw[K_PAUSE] = key_hit(keycode, HID_P);
`ifdef KEY_ARROWS_EN
      raw[K_UP]    = raw[K_UP]    | key_hit(keycode, HID_UP);
      raw[K_RIGHT] = raw[K_RIGHT] | key_hit(keycode, HID_RIGHT);
      raw[K_DOWN]  = raw[K_DOWN]  | key_hit(keycode, HID_DOWN);
      raw[K_LEFT]  = raw[K_LEFT]  | key_hit(keycode, HID_LEFT);
`endif
   end

   for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
      key_debounce #(
         .DEBOUNCE (DEBOUNCE)
      ) u_deb (
         .frame_clk (frame_clk),
         .Reset     (Reset),
         .raw       (raw[k]),
         .level     (lvl[k]),
         .rise      (rise[k]),
         .fall      (fall[k])
      );
   end

   // Fire and pause act on edges only; their levels and fire release are not needed.
   assign unused_keys = ^{lvl[K_FIRE], lvl[K_PAUSE], fall[K_FIRE], fall[K_PAUSE]};

   // Direction arbitration: a new press takes over, losing the active key falls back to the best held one.
   always_comb begin
      act_dir_nx = act_dir;
      act_mv_nx  = act_mv;
      if (rise[3:0] != 4'b0000) begin
         act_dir_nx = pick_dir(rise[3:0]);
         act_mv_nx  = 1'b1;
      end else if (lvl[3:0] == 4'b0000) begin
         act_mv_nx  = 1'b0;
      end else if (fall[act_dir]) begin
         act_dir_nx = pick_dir(lvl[3:0]);
         act_mv_nx  = 1'b1;
      end
   end

   // Pause toggles first; fire and cooldown then see the resulting pause state.
   always_comb begin
      paused_nx   = paused ^ rise[K_PAUSE];
      hold_out    = paused | paused_nx;
      fire_nx     = 1'b0;
      cooldown_nx = cooldown;
      if (!paused_nx) begin
         if (rise[K_FIRE] && (cooldown == 8'd0)) begin
            fire_nx     = 1'b1;
            cooldown_nx = CD_LOAD;
         end else if (cooldown != 8'd0) begin
            cooldown_nx = cooldown - 8'd1;
         end
      end
   end

   // Arbitration state keeps running while paused; the visible outputs are frozen until a full unpaused frame.
   always_ff @(posedge frame_clk or negedge Reset) begin
      if (!Reset) begin
         act_dir  <= UP;
         act_mv   <= 1'b0;
         paused   <= 1'b0;
         cooldown <= 8'd0;
         fire     <= 1'b0;
         move     <= 1'b0;
         dir      <= UP;
      end else begin
         act_dir  <= act_dir_nx;
         act_mv   <= act_mv_nx;
         paused   <= paused_nx;
         cooldown <= cooldown_nx;
         fire     <= fire_nx;
         move     <= act_mv_nx & ~hold_out;
         if (!hold_out) begin
            dir <= act_dir_nx;
         end
      end
   end

endmodule

// File: tb/tb_key_input_controller.sv
// Scoreboard bench for key_input_controller (DEBOUNCE = 2, FIRE_COOLDOWN = 30).
// Each frame step drives a keycode and queues the outputs expected after the
// next rising edge; a monitor pops and compares them 1 time unit after that edge.
module tb_key_input_controller;

   logic        frame_clk = 1'b0;
   logic        Reset     = 1'b0;
   logic [15:0] keycode   = 16'h0000;
   logic        move;
   logic [1:0]  dir;
   logic        fire;
   logic        paused;

`ifdef KEY_ARROWS_EN
   localparam bit ARW = 1'b1;
`else
   localparam bit ARW = 1'b0;
`endif

   typedef struct {
      int         idx;
      logic       m;
      logic [1:0] d;
      logic       f;
      logic       p;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   stepno = 0;
   int   n_cmp  = 0;
   int   n_err  = 0;

   key_input_controller #(
      .DEBOUNCE      (2),
      .FIRE_COOLDOWN (30)
   ) dut (
      .frame_clk (frame_clk),
      .Reset     (Reset),
      .keycode   (keycode),
      .move      (move),
      .dir       (dir),
      .fire      (fire),
      .paused    (paused)
   );

   always #5 frame_clk = ~frame_clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, want);
      end
   endtask

   // Drive one frame's keycode and queue what the outputs must be after the next edge.
   task automatic step(input logic [15:0] kc, input logic m, input logic [1:0] d,
                       input logic f, input logic p);
      exp_t e;
      @(posedge frame_clk);
      #2;
      keycode = kc;
      e.idx = stepno;
      e.m   = m;
      e.d   = d;
      e.f   = f;
      e.p   = p;
      sb.push_back(e);
      stepno++;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, ".move"},   32'(move),   32'd0);
      chk({tag, ".dir"},    32'(dir),    32'd0);
      chk({tag, ".fire"},   32'(fire),   32'd0);
      chk({tag, ".paused"}, 32'(paused), 32'd0);
   endtask

   always @(posedge frame_clk) begin
      #1;
      if (sb.size() > 0) begin
         mon_e = sb.pop_front();
         chk($sformatf("s%0d.move",   mon_e.idx), 32'(move),   32'(mon_e.m));
         chk($sformatf("s%0d.dir",    mon_e.idx), 32'(dir),    32'(mon_e.d));
         chk($sformatf("s%0d.fire",   mon_e.idx), 32'(fire),   32'(mon_e.f));
         chk($sformatf("s%0d.paused", mon_e.idx), 32'(paused), 32'(mon_e.p));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (2) @(posedge frame_clk);
      #1;
      chk_reset_outputs("rst0");
      @(posedge frame_clk);
      #2;
      Reset = 1'b1;

      for (int i = 0; i < 2; i++) step(16'h0000, 1'b0, 2'd0, 1'b0, 1'b0);

      // W alone: move on the third edge; release: move drops on the third edge
      for (int i = 0; i < 4; i++) step(16'h001A, i >= 2, 2'd0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(16'h0000, i < 2, 2'd0, 1'b0, 1'b0);

      // W held, D added in slot B takes over; releasing D falls back to W
      for (int i = 0; i < 3; i++) step(16'h001A, i == 2, 2'd0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(16'h071A, 1'b1, (i == 2) ? 2'd1 : 2'd0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(16'h001A, 1'b1, (i == 2) ? 2'd0 : 2'd1, 1'b0, 1'b0);

      // One-sample dropout of W: no fall
      step(16'h0000, 1'b1, 2'd0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(16'h001A, 1'b1, 2'd0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(16'h0000, i < 2, 2'd0, 1'b0, 1'b0);

      // S and A rise together: DOWN wins; releasing S leaves LEFT
      for (int i = 0; i < 3; i++) step(16'h0416, i == 2, (i == 2) ? 2'd2 : 2'd0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(16'h0400, 1'b1, (i == 2) ? 2'd3 : 2'd2, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(16'h0000, i < 2, 2'd3, 1'b0, 1'b0);

      // Space toggled every 4 frames: shots at relative frames 2 and 34 only
      for (int i = 0; i < 40; i++)
         step(((i % 8) < 4) ? 16'h002C : 16'h0000, 1'b0, 2'd3, (i == 2) || (i == 34), 1'b0);
      for (int i = 0; i < 30; i++) step(16'h0000, 1'b0, 2'd3, 1'b0, 1'b0);

      // Space held 100 frames: exactly one shot
      for (int i = 0; i < 100; i++) step(16'h002C, 1'b0, 2'd3, i == 2, 1'b0);
      for (int i = 0; i < 3; i++) step(16'h0000, 1'b0, 2'd3, 1'b0, 1'b0);

      // Pause, then W + Space while paused: nothing leaves; unpause with W held
      for (int i = 0; i < 3; i++) step(16'h0013, 1'b0, 2'd3, 1'b0, i == 2);
      for (int i = 0; i < 3; i++) step(16'h0000, 1'b0, 2'd3, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) step(16'h2C1A, 1'b0, 2'd3, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) step(16'h131A, i == 3, (i == 3) ? 2'd0 : 2'd3, 1'b0, i < 2);
      for (int i = 0; i < 3; i++) step(16'h0000, i < 2, 2'd0, 1'b0, 1'b0);

      // Pause and Space rise together: shot suppressed and cooldown left idle
      for (int i = 0; i < 3; i++) step(16'h2C13, 1'b0, 2'd0, 1'b0, i == 2);
      for (int i = 0; i < 3; i++) step(16'h0000, 1'b0, 2'd0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step(16'h0013, 1'b0, 2'd0, 1'b0, i < 2);
      for (int i = 0; i < 3; i++) step(16'h0000, 1'b0, 2'd0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(16'h002C, 1'b0, 2'd0, i == 2, 1'b0);

      // D held during cooldown, then asynchronous reset mid-frame
      for (int i = 0; i < 3; i++) step(16'h0007, i == 2, (i == 2) ? 2'd1 : 2'd0, 1'b0, 1'b0);
      @(posedge frame_clk);
      #4;
      Reset = 1'b0;
      #1;
      chk_reset_outputs("rst_async");
      @(posedge frame_clk);
      #1;
      chk_reset_outputs("rst_hold");

      // Release with D still held: full debounce again; cooldown was cleared
      step(16'h0007, 1'b0, 2'd0, 1'b0, 1'b0);
      Reset = 1'b1;
      step(16'h0007, 1'b0, 2'd0, 1'b0, 1'b0);
      step(16'h0007, 1'b1, 2'd1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(16'h2C07, 1'b1, 2'd1, i == 2, 1'b0);
      step(16'h0007, 1'b1, 2'd1, 1'b0, 1'b0);

      // Arrow Down in slot B
      for (int i = 0; i < 3; i++) step(16'h0000, i < 2, 2'd1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++)
         step(16'h5100, (i == 2) && ARW, ((i == 2) && ARW) ? 2'd2 : 2'd1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(16'h0000, ARW && (i < 2), ARW ? 2'd2 : 2'd1, 1'b0, 1'b0);

      repeat (2) @(posedge frame_clk);
      #3;
      chk("drain", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
